// File: rtl/wb_stage_pkg.sv
// Shared constants, state encoding and result-select helper for the write-back stage.
// Imported by the interface, the register file and the top level.
package wb_stage_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 16;
    localparam int RW     = $clog2(NREGS);
    localparam int RA_IDX = 15;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_e;

    // A load takes precedence over a call when both flags are set.
    function automatic logic [XLEN-1:0] selResult(
        input logic            isLd,
        input logic            isCall,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] aluResult,
        input logic [XLEN-1:0] ldResult
    );
        if (isLd)
            return ldResult;
        else if (isCall)
            return pc + XLEN'(4);
        else
            return aluResult;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-access to write-back handoff bundle.
// The MA side drives the instruction fields; the WB side drives in_ready.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            isLd;
    logic            isCall;
    logic            isWb;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] ldResult;
    logic [RW-1:0]   rd;

    modport master (
        output in_valid, isLd, isCall, isWb, pc, aluResult, ldResult, rd,
        input  in_ready
    );

    modport slave (
        input  in_valid, isLd, isCall, isWb, pc, aluResult, ldResult, rd,
        output in_ready
    );

endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read ports.
// A write in the current cycle is visible on the read ports in that same cycle.
module wb_regfile
    import wb_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // Every register, r0 included, is an ordinary writable register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && (waddr == raddr1))
            rdata1 = wdata;
        if (we && (waddr == raddr2))
            rdata2 = wdata;
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry MA/WB latch, result select, register-file commit
// with decode bypass, forwarding hint and retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    wb_stage_if.slave        bus,
    input  logic             hold,
    input  logic             flush,
    input  logic [RW-1:0]    rs1_addr,
    input  logic [RW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             fwd_valid,
    output logic [RW-1:0]    fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [31:0]      retired_count
);

    wb_state_e       state;
    wb_state_e       nextState;
    logic            doCapture;
    logic            doCommit;
    logic            inReady;
    logic [XLEN-1:0] resultQ;
    logic [RW-1:0]   destQ;
    logic            wbQ;
    logic [31:0]     retiredQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= EMPTY;
        else
            state <= nextState;
    end

    // Flush outranks everything; a simultaneous commit and capture keeps the latch full.
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        doCommit  = 1'b0;
        doCapture = 1'b0;
        if (!flush) begin
            inReady   = (state == EMPTY) || !hold;
            doCommit  = (state == FULL) && !hold;
            doCapture = bus.in_valid && inReady;
        end
        if (flush)
            nextState = EMPTY;
        else if (doCapture)
            nextState = FULL;
        else if (doCommit)
            nextState = EMPTY;
    end

    assign bus.in_ready = inReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resultQ <= '0;
            destQ   <= '0;
            wbQ     <= 1'b0;
        end else if (doCapture) begin
            resultQ <= selResult(bus.isLd, bus.isCall, bus.pc, bus.aluResult, bus.ldResult);
            destQ   <= bus.isCall ? RW'(RA_IDX) : bus.rd;
            wbQ     <= bus.isWb;
        end
    end

    // Retirement counts every commit, including instructions that write no register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retiredQ <= '0;
        else if (doCommit)
            retiredQ <= retiredQ + 32'd1;
    end

    assign retired_count = retiredQ;

    wb_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (doCommit && wbQ),
        .waddr  (destQ),
        .wdata  (resultQ),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    assign fwd_valid = (state == FULL) && wbQ;
    assign fwd_rd    = (state == FULL) ? destQ   : '0;
    assign fwd_data  = (state == FULL) ? resultQ : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: inputs change and outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic             clk;
    logic             reset;
    logic             hold;
    logic             flush;
    logic [RW-1:0]    rs1_addr;
    logic [RW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             fwd_valid;
    logic [RW-1:0]    fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [31:0]      retired_count;
    int               total;
    int               bad;

    wb_stage_if bus ();

    wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .hold          (hold),
        .flush         (flush),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic        valid,
        input logic        ld,
        input logic        call,
        input logic        wb,
        input logic [31:0] pcVal,
        input logic [31:0] alu,
        input logic [31:0] ldData,
        input logic [3:0]  dest,
        input logic        holdVal,
        input logic        flushVal
    );
        bus.in_valid  = valid;
        bus.isLd      = ld;
        bus.isCall    = call;
        bus.isWb      = wb;
        bus.pc        = pcVal;
        bus.aluResult = alu;
        bus.ldResult  = ldData;
        bus.rd        = dest;
        hold          = holdVal;
        flush         = flushVal;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        rs1_addr = 4'd0;
        rs2_addr = 4'd15;
        idle();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_rs1", rs1_data, 32'h0);
        checkOutput("reset_rs2", rs2_data, 32'h0);
        checkOutput("reset_count", retired_count, 32'h0);
        checkOutput("reset_fwd_valid", 32'(fwd_valid), 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);

        // ALU write-back to r3
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1234, 32'h0, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        rs1_addr = 4'd3;
        #1;
        checkOutput("alu_fwd_valid", 32'(fwd_valid), 32'h1);
        checkOutput("alu_fwd_rd", 32'(fwd_rd), 32'h3);
        checkOutput("alu_fwd_data", fwd_data, 32'h1234);
        checkOutput("alu_count_before", retired_count, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("alu_r3", rs1_data, 32'h1234);
        checkOutput("alu_count", retired_count, 32'h1);
        checkOutput("alu_fwd_data_empty", fwd_data, 32'h0);

        // Back-to-back load then call
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1111, 32'hDEADBEEF, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h2222, 32'h0, 4'd2, 1'b0, 1'b0);
        #1;
        checkOutput("ld_in_ready_full", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        idle();
        rs1_addr = 4'd5;
        rs2_addr = 4'd15;
        #1;
        checkOutput("ld_r5", rs1_data, 32'hDEADBEEF);
        checkOutput("call_r15_bypass", rs2_data, 32'h44);
        checkOutput("call_fwd_rd", 32'(fwd_rd), 32'd15);
        checkOutput("ld_count", retired_count, 32'h2);
        @(negedge clk);
        rs1_addr = 4'd2;
        #1;
        checkOutput("call_r15", rs2_data, 32'h44);
        checkOutput("call_r2_untouched", rs1_data, 32'h0);
        checkOutput("call_count", retired_count, 32'h3);

        // Same-cycle bypass of a commit to r7
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hA5, 32'h0, 4'd7, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        rs1_addr = 4'd7;
        #1;
        checkOutput("bypass_r7", rs1_data, 32'hA5);
        @(negedge clk);
        #1;
        checkOutput("bypass_count", retired_count, 32'h4);

        // Hold three cycles while full, with a competing valid input
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h77, 32'h0, 4'd8, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h99, 32'h0, 4'd9, 1'b1, 1'b0);
        rs1_addr = 4'd8;
        rs2_addr = 4'd9;
        #1;
        checkOutput("hold_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("hold_no_bypass", rs1_data, 32'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("hold_fwd_data", fwd_data, 32'h77);
            checkOutput("hold_count", retired_count, 32'h4);
            checkOutput("hold_r8", rs1_data, 32'h0);
        end
        @(negedge clk);
        idle();
        #1;
        checkOutput("hold_release_r8", rs1_data, 32'h77);
        @(negedge clk);
        #1;
        checkOutput("hold_release_count", retired_count, 32'h5);
        checkOutput("hold_r9_never", rs2_data, 32'h0);

        // Flush with a full latch and a valid input
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h55, 32'h0, 4'd10, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h66, 32'h0, 4'd11, 1'b0, 1'b1);
        rs1_addr = 4'd10;
        rs2_addr = 4'd11;
        #1;
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("flush_no_bypass", rs1_data, 32'h0);
        @(negedge clk);
        idle();
        #1;
        checkOutput("flush_fwd_valid", 32'(fwd_valid), 32'h0);
        checkOutput("flush_count", retired_count, 32'h5);
        checkOutput("flush_r10", rs1_data, 32'h0);
        checkOutput("flush_r11", rs2_data, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("flush_count_later", retired_count, 32'h5);

        // Counter wrap on a commit that writes no register
        @(negedge clk);
        force dut.retiredQ = 32'hFFFF_FFFF;
        #1;
        release dut.retiredQ;
        checkOutput("wrap_preload", retired_count, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hBEEF, 32'h0, 4'd7, 1'b0, 1'b0);
        rs1_addr = 4'd7;
        @(negedge clk);
        idle();
        #1;
        checkOutput("wrap_no_bypass", rs1_data, 32'hA5);
        @(negedge clk);
        #1;
        checkOutput("wrap_count", retired_count, 32'h0);
        checkOutput("wrap_r7", rs1_data, 32'hA5);

        // Asynchronous reset mid-operation with an entry in flight
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3C, 32'h0, 4'd4, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset_r7", rs1_data, 32'h0);
        checkOutput("midreset_count", retired_count, 32'h0);
        checkOutput("midreset_fwd_valid", 32'(fwd_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rs2_addr = 4'd4;
        #1;
        checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        #1;
        checkOutput("midreset_r4_lost", rs2_data, 32'h0);
        checkOutput("midreset_count_after", retired_count, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
